// File: rtl/uart_pkg.sv
// Constants, arbiter state type and width helper shared by the UART transmit-side blocks.
package uart_pkg;

    localparam int D_BIT       = 7;
    localparam int UART_DATA_W = D_BIT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) < value) result = r + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority select: first valid requester at or after i_rr_ptr, wrapping at N_REQ.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        i_valid,
    input  logic [clog2(N_REQ)-1:0] i_rr_ptr,
    output logic [clog2(N_REQ)-1:0] o_sel,
    output logic                    o_any
);

    localparam int IDX_W = clog2(N_REQ);

    // Scan from the farthest offset down so the nearest valid requester is the last to write.
    always_comb begin
        // NOTE: every output gets a default first so no path through the loop can infer a latch.
        o_sel = '0;
        o_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_valid[(int'(i_rr_ptr) + k) % N_REQ]) begin
                o_sel = IDX_W'((int'(i_rr_ptr) + k) % N_REQ);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources: round-robin per frame, one start
// pulse per byte, frame lock until the last byte, and a watchdog that aborts stuck frames.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       tx_dato_in,
    output logic                    tx_start,
    input  logic                    tx_done,
    output logic [clog2(N_REQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int               GID_W    = clog2(N_REQ);
    localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [GID_W-1:0] GID_MAX  = GID_W'(N_REQ - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [GID_W-1:0]  r_rr_ptr;
    logic [GID_W-1:0]  r_grant_id;
    logic [GID_W-1:0]  w_sel;
    logic [GID_W-1:0]  w_xfer_id;
    logic [GID_W-1:0]  w_grant_nxt;
    logic [DATA_W-1:0] r_dato;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;
    logic              r_tx_start;
    logic              r_timeout_err;
    logic              w_any;
    logic              w_xfer;
    logic              w_expire;
    logic              w_abort;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .i_valid  (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_sel    (w_sel),
        .o_any    (w_any)
    );

    assign w_xfer_id   = (r_state == LOCK) ? r_grant_id : w_sel;
    assign w_xfer      = |(req_valid & req_ready);
    assign w_expire    = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);
    assign w_grant_nxt = (r_grant_id == GID_MAX) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A completing byte beats watchdog expiry; a transfer in LOCK beats it as well.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        unique case (r_state)
            IDLE: if (w_xfer) w_next = WAIT;
            WAIT: begin
                if (tx_done) begin
                    w_next = r_last ? IDLE : LOCK;
                end else if (w_expire) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            LOCK: begin
                if (w_xfer) begin
                    w_next = WAIT;
                end else if (w_expire) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        unique case (r_state)
            IDLE:    if (w_any) req_ready[w_sel] = 1'b1;
            WAIT:    busy = 1'b1;
            LOCK: begin
                req_ready[r_grant_id] = req_valid[r_grant_id];
                busy                  = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_dato        <= '0;
            r_last        <= 1'b0;
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            r_tx_start    <= w_xfer;
            r_timeout_err <= w_abort;
            if (w_xfer) begin
                r_grant_id <= w_xfer_id;
                r_dato     <= req_data[w_xfer_id*DATA_W +: DATA_W];
                r_last     <= req_last[w_xfer_id];
            end
            if ((r_state == WAIT && tx_done && r_last) || w_abort) r_rr_ptr <= w_grant_nxt;
            if (w_next != r_state)    r_cnt <= '0;
            else if (r_state != IDLE) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tx_dato_in  = r_dato;
    assign tx_start    = r_tx_start;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

endmodule
